// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: FSM encoding, default widths and tap-index helpers.
package cnn_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 32;
    localparam int unsigned WIDTH_DEF      = 16;
    localparam int unsigned K_DEF          = 5;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StScan  = 2'd1,
        StDrain = 2'd2
    } fsm_state_e;

    // Tap i of a KxK window sits at row ky(i), column kx(i) (row-major).
    function automatic int unsigned ky(input int unsigned i, input int unsigned k);
        return i / k;
    endfunction

    function automatic int unsigned kx(input int unsigned i, input int unsigned k);
        return i % k;
    endfunction

endpackage

// File: rtl/conv_win_addr_calc.sv
// Combinational window address generator: one buffer address per KxK tap.
module conv_win_addr_calc
    import cnn_pkg::*;
#(
    parameter int unsigned IMG_W        = 32,
    parameter int unsigned K            = K_DEF,
    parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int unsigned OUT_PORT_NUM = K * K
) (
    input  logic [ADDR_WIDTH-1:0]              i_base,
    input  logic [15:0]                        i_row,
    input  logic [15:0]                        i_col,
    output logic [OUT_PORT_NUM*ADDR_WIDTH-1:0] o_addr
);

    for (genvar gi = 0; gi < OUT_PORT_NUM; gi++) begin : g_tap
        localparam int unsigned TapY = ky(gi, K);
        localparam int unsigned TapX = kx(gi, K);

        logic [ADDR_WIDTH-1:0] w_row_off;
        logic [ADDR_WIDTH-1:0] w_col_off;

        // Arithmetic wraps at 2^ADDR_WIDTH by construction.
        assign w_row_off = (ADDR_WIDTH'(i_row) + ADDR_WIDTH'(TapY)) * ADDR_WIDTH'(IMG_W);
        assign w_col_off = ADDR_WIDTH'(i_col) + ADDR_WIDTH'(TapX);
        assign o_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] = i_base + w_row_off + w_col_off;
    end

endmodule

// File: rtl/conv_window_fetch.sv
// Raster scan of a KxK valid-conv window over a feature map; fetches all taps from a
// multi-port buffer in one cycle and presents the registered window on valid/ready.
module conv_window_fetch
    import cnn_pkg::*;
#(
    parameter int unsigned IMG_W        = 32,
    parameter int unsigned IMG_H        = 32,
    parameter int unsigned K            = K_DEF,
    parameter int unsigned WIDTH        = WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int unsigned OUT_PORT_NUM = K * K
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_start,
    input  logic [ADDR_WIDTH-1:0]              i_base_addr,
    output logic                               o_busy,
    output logic                               o_done,
    output logic [OUT_PORT_NUM*ADDR_WIDTH-1:0] o_rd_addr_NP,
    input  logic [OUT_PORT_NUM*WIDTH-1:0]      i_rd_data_NP,
    output logic [OUT_PORT_NUM*WIDTH-1:0]      o_win_data,
    output logic                               o_win_valid,
    input  logic                               i_win_ready,
    output logic [15:0]                        o_win_row,
    output logic [15:0]                        o_win_col
);

    localparam int unsigned OUT_W = IMG_W - K + 1;
    localparam int unsigned OUT_H = IMG_H - K + 1;
    localparam logic [15:0] LastCol = 16'(OUT_W - 1);
    localparam logic [15:0] LastRow = 16'(OUT_H - 1);

    fsm_state_e                      r_state;
    logic [ADDR_WIDTH-1:0]           r_base;
    logic [15:0]                     r_row;
    logic [15:0]                     r_col;
    logic [OUT_PORT_NUM*WIDTH-1:0]   r_win_data;
    logic                            r_win_valid;
    logic [15:0]                     r_win_row;
    logic [15:0]                     r_win_col;
    logic                            r_done;
    logic                            w_capture;

    conv_win_addr_calc #(
        .IMG_W        (IMG_W),
        .K            (K),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .OUT_PORT_NUM (OUT_PORT_NUM)
    ) u_addr_calc (
        .i_base (r_base),
        .i_row  (r_row),
        .i_col  (r_col),
        .o_addr (o_rd_addr_NP)
    );

    // Output slot is free when empty or being drained this cycle.
    assign w_capture = !r_win_valid || i_win_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_base      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_win_data  <= '0;
            r_win_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_base  <= i_base_addr;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_state <= StScan;
                    end
                end
                StScan: begin
                    if (w_capture) begin
                        r_win_data  <= i_rd_data_NP;
                        r_win_row   <= r_row;
                        r_win_col   <= r_col;
                        r_win_valid <= 1'b1;
                        if (r_col == LastCol) begin
                            r_col <= '0;
                            r_row <= r_row + 16'd1;
                            if (r_row == LastRow) begin
                                r_state <= StDrain;
                            end
                        end else begin
                            r_col <= r_col + 16'd1;
                        end
                    end
                end
                StDrain: begin
                    if (r_win_valid && i_win_ready) begin
                        r_win_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_busy      = (r_state != StIdle);
    assign o_done      = r_done;
    assign o_win_data  = r_win_data;
    assign o_win_valid = r_win_valid;
    assign o_win_row   = r_win_row;
    assign o_win_col   = r_win_col;

endmodule

// File: tb/tb_conv_window_fetch.sv
// Bench for conv_window_fetch on an 8x8 map with K=5: behavioural window model, per-cycle
// compare process, randomized backpressure and bases.
module tb_conv_window_fetch;

    localparam int unsigned IMG_W = 8;
    localparam int unsigned IMG_H = 8;
    localparam int unsigned K     = 5;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned AW    = 32;
    localparam int unsigned NP    = K * K;
    localparam int          OUT_W = IMG_W - K + 1;
    localparam int          OUT_H = IMG_H - K + 1;
    localparam int          NWIN  = OUT_W * OUT_H;

    typedef logic [NP*WIDTH-1:0] win_t;
    typedef struct {
        int   row;
        int   col;
        win_t data;
        bit   last;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              i_start;
    logic [AW-1:0]     i_base_addr;
    logic              o_busy;
    logic              o_done;
    logic [NP*AW-1:0]  o_rd_addr_NP;
    logic [NP*WIDTH-1:0] i_rd_data_NP;
    win_t              o_win_data;
    logic              o_win_valid;
    logic              i_win_ready;
    logic [15:0]       o_win_row;
    logic [15:0]       o_win_col;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   first_vld_cyc = -1;
    int   done_cyc = -1;
    int   hs_cnt = 0;
    bit   done_exp = 0;
    bit   hold = 0;
    win_t held_data;
    int   held_row, held_col;
    bit   rnd_ready = 0;
    bit   ready_lvl = 1;
    exp_t exp_q[$];

    conv_window_fetch #(
        .IMG_W        (IMG_W),
        .IMG_H        (IMG_H),
        .K            (K),
        .WIDTH        (WIDTH),
        .ADDR_WIDTH   (AW),
        .OUT_PORT_NUM (NP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_rd_addr_NP (o_rd_addr_NP),
        .i_rd_data_NP (i_rd_data_NP),
        .o_win_data   (o_win_data),
        .o_win_valid  (o_win_valid),
        .i_win_ready  (i_win_ready),
        .o_win_row    (o_win_row),
        .o_win_col    (o_win_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer model: mem[a] = a & 0xFFFF, combinational read.
    always_comb begin
        i_rd_data_NP = '0;
        for (int i = 0; i < NP; i++) begin
            i_rd_data_NP[i*WIDTH +: WIDTH] = o_rd_addr_NP[i*AW +: WIDTH];
        end
    end

    function automatic logic [31:0] tap_addr(input logic [31:0] base, input int r, input int c,
                                             input int i);
        return base + 32'((r + i / K) * IMG_W + c + i % K);
    endfunction

    function automatic win_t model_win(input logic [31:0] base, input int r, input int c);
        win_t        w;
        logic [31:0] a;
        for (int i = 0; i < NP; i++) begin
            a = tap_addr(base, r, c, i);
            w[i*WIDTH +: WIDTH] = a[15:0];
        end
        return w;
    endfunction

    function automatic logic [15:0] tap(input win_t w, input int i);
        return w[i*WIDTH +: WIDTH];
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_win(input string name, input win_t got, input win_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_scan(input logic [31:0] base);
        exp_t e;
        for (int r = 0; r < OUT_H; r++) begin
            for (int c = 0; c < OUT_W; c++) begin
                e.row  = r;
                e.col  = c;
                e.data = model_win(base, r, c);
                e.last = (r == OUT_H - 1) && (c == OUT_W - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Compare process: runs every falling edge while out of reset.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            hold     = 0;
            done_exp = 0;
        end else begin
            check("done_pulse", o_done, done_exp);
            if (o_done) done_cyc = cyc;
            done_exp = 0;
            if (hold) begin
                check("hold_valid", o_win_valid, 1);
                check_win("hold_data", o_win_data, held_data);
                check("hold_row", o_win_row, held_row);
                check("hold_col", o_win_col, held_col);
            end
            if (o_win_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            hold      = o_win_valid && !i_win_ready;
            held_data = o_win_data;
            held_row  = o_win_row;
            held_col  = o_win_col;
            if (o_win_valid && i_win_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("extra_window", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_win("win_data", o_win_data, e.data);
                    check("win_row", o_win_row, e.row);
                    check("win_col", o_win_col, e.col);
                    done_exp = e.last;
                end
            end
        end
    end

    initial begin
        i_win_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) i_win_ready = 1'($urandom_range(0, 1));
            else           i_win_ready = ready_lvl;
        end
    end

    task automatic do_start(input logic [31:0] base);
        push_scan(base);
        hs_cnt        = 0;
        first_vld_cyc = -1;
        @(posedge clk);
        #1;
        i_base_addr = base;
        i_start     = 1'b1;
        start_cyc   = cyc + 1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    // Wait for done; optionally spam start while busy, optionally restart in the done cycle.
    task automatic wait_done(input bit spam, input bit restart, input logic [31:0] rbase);
        bit seen = 0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (o_done) begin
                seen = 1;
                i_start = restart;
                if (restart) begin
                    push_scan(rbase);
                    i_base_addr   = rbase;
                    hs_cnt        = 0;
                    first_vld_cyc = -1;
                    start_cyc     = cyc;
                end
            end else begin
                i_start = spam && o_busy && ($urandom_range(0, 1) == 1);
            end
        end
        check("done_seen", seen, 1);
        if (restart) begin
            @(posedge clk);
            #1;
            i_start = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] rb;
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_base_addr = '0;
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_valid", o_win_valid, 0);
        check("rst_done", o_done, 0);
        check("rst_row", o_win_row, 0);
        check("rst_col", o_win_col, 0);
        check_win("rst_data", o_win_data, '0);
        check("rst_addr24", o_rd_addr_NP[24*AW +: AW], tap_addr(0, 0, 0, 24));

        // Literal pins on the model itself.
        check("model_first_p0", tap(model_win(0, 0, 0), 0), 16'd0);
        check("model_first_p24", tap(model_win(0, 0, 0), 24), 16'd36);
        check("model_last_p0", tap(model_win(0, 3, 3), 0), 16'd27);
        check("model_last_p24", tap(model_win(0, 3, 3), 24), 16'd63);
        check("model_off_p0", tap(model_win(100, 0, 0), 0), 16'd100);
        check("model_off_p4", tap(model_win(100, 0, 0), 4), 16'd104);
        check("model_off_p24", tap(model_win(100, 0, 0), 24), 16'd136);
        check("model_off_12_p0", tap(model_win(100, 1, 2), 0), 16'd110);

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic scan with ready held high.
        ready_lvl = 1;
        rnd_ready = 0;
        repeat (2) @(posedge clk);
        do_start(0);
        check("busy_after_start", o_busy, 1);
        wait_done(0, 0, 0);
        check("basic_first_valid_rel", first_vld_cyc - start_cyc, 2);
        check("basic_done_rel", done_cyc - start_cyc, 18);
        check("basic_count", hs_cnt, NWIN);
        check("basic_q_empty", exp_q.size(), 0);
        check("idle_busy", o_busy, 0);

        // Random backpressure.
        rnd_ready = 1;
        do_start(0);
        wait_done(0, 0, 0);
        check("bp_count", hs_cnt, NWIN);
        check("bp_q_empty", exp_q.size(), 0);

        // Offset base.
        do_start(100);
        wait_done(0, 0, 0);
        check("off_count", hs_cnt, NWIN);
        check("off_q_empty", exp_q.size(), 0);

        // Starts while busy are ignored; a start in the done cycle restarts.
        do_start(200);
        wait_done(1, 1, 300);
        check("spam_q_len", exp_q.size(), NWIN);
        wait_done(1, 0, 0);
        check("restart_first_valid_rel", first_vld_cyc - start_cyc, 2);
        check("restart_count", hs_cnt, NWIN);
        check("restart_q_empty", exp_q.size(), 0);

        // Reset mid-scan.
        rnd_ready = 0;
        ready_lvl = 1;
        do_start(0);
        for (int n = 0; n < 100 && hs_cnt < 5; n++) begin
            @(negedge clk);
            #1;
        end
        check("pre_reset_hs", hs_cnt, 5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_valid", o_win_valid, 0);
        check("mid_rst_done", o_done, 0);
        exp_q.delete();
        hold     = 0;
        done_exp = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_start(0);
        for (int n = 0; n < 20 && !o_win_valid; n++) begin
            @(negedge clk);
            #1;
        end
        check("post_rst_valid", o_win_valid, 1);
        check("post_rst_row", o_win_row, 0);
        check("post_rst_col", o_win_col, 0);
        wait_done(0, 0, 0);
        check("post_rst_q_empty", exp_q.size(), 0);

        // Random bases, including address wrap, with random backpressure.
        rnd_ready = 1;
        for (int t = 0; t < 4; t++) begin
            rb = (t == 0) ? 32'hFFFF_FFF0 : $urandom;
            do_start(rb);
            wait_done(1, 0, 0);
            check("rand_count", hs_cnt, NWIN);
            check("rand_q_empty", exp_q.size(), 0);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
